// File: rtl/unit_sched.sv
// unit_sched: per-unit-class issue scheduler.
// Tracks commit slots waiting for one class of functional unit and, each
// cycle, hands the oldest eligible slots (relative to commit_head) to up to
// NUNIT free units. Units may be multi-cycle and non-pipelined (busy counters).
//
// Handshake: issue_valid[u] is a one-cycle push with no back-pressure from the
// scheduler side. The unit refuses work for the current cycle by asserting
// unit_stall[u]; a stalled or busy unit never sees issue_valid[u]=1, so
// issue_valid[u]=1 always means the slot in field u has been taken this cycle.
module unit_sched #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = $clog2(NCOMMIT),
    parameter int NUNIT    = 2,
    parameter int LATENCY  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCOMMIT-1:0]        alloc,
    input  logic [NCOMMIT-1:0]        ready,
    input  logic [NCOMMIT-1:0]        kill,
    input  logic [LNCOMMIT-1:0]       commit_head,
    input  logic [NUNIT-1:0]          unit_stall,
    output logic [NUNIT-1:0]          issue_valid,
    output logic [NUNIT*LNCOMMIT-1:0] issue_slot,
    output logic [NCOMMIT-1:0]        pending,
    output logic [NUNIT-1:0]          unit_busy
);

    // Busy counters hold up to 15 remaining cycles.
    localparam int CW = 4;

    logic [NCOMMIT-1:0]        pending_q, pending_d;
    logic [NCOMMIT-1:0]        eligible;
    logic [NCOMMIT-1:0]        rot;
    logic [NCOMMIT-1:0]        remaining;
    logic [NCOMMIT-1:0]        issued;
    logic [NUNIT-1:0]          free;
    logic [NUNIT-1:0]          valid_c;
    logic [NUNIT*LNCOMMIT-1:0] slot_c;
    logic                      found;
    logic [LNCOMMIT-1:0]       kpos;
    logic [LNCOMMIT-1:0]       sel_slot;
    logic [CW-1:0]             cnt_q [NUNIT];
    logic [CW-1:0]             cnt_d [NUNIT];

    // Eligibility, free units and rotation into age order (bit 0 = oldest).
    always_comb begin
        eligible = pending_q & ready & ~kill;
        rot      = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            rot[i] = eligible[commit_head + LNCOMMIT'(i)];
        end
        for (int u = 0; u < NUNIT; u++) begin
            free[u] = ~unit_stall[u] & (cnt_q[u] == '0);
        end
    end

    // Free units in ascending order take successive oldest eligible slots.
    always_comb begin
        remaining = rot;
        valid_c   = '0;
        slot_c    = '0;
        issued    = '0;
        found     = 1'b0;
        kpos      = '0;
        sel_slot  = '0;
        for (int u = 0; u < NUNIT; u++) begin
            found = 1'b0;
            kpos  = '0;
            for (int k = 0; k < NCOMMIT; k++) begin
                if (!found && remaining[k]) begin
                    found = 1'b1;
                    kpos  = LNCOMMIT'(k);
                end
            end
            if (free[u] && !reset && found) begin
                remaining[kpos]                = 1'b0;
                sel_slot                       = commit_head + kpos;
                valid_c[u]                     = 1'b1;
                slot_c[u*LNCOMMIT +: LNCOMMIT] = sel_slot;
                issued[sel_slot]               = 1'b1;
            end
        end
    end

    // Next pending mask: kill beats alloc, alloc beats issue-clear.
    always_comb begin
        pending_d = ((pending_q & ~issued) | alloc) & ~kill;
        for (int u = 0; u < NUNIT; u++) begin
            if (valid_c[u]) begin
                cnt_d[u] = CW'(LATENCY - 1);
            end else if (cnt_q[u] != '0) begin
                cnt_d[u] = cnt_q[u] - CW'(1);
            end else begin
                cnt_d[u] = '0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            for (int u = 0; u < NUNIT; u++) begin
                cnt_q[u] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int u = 0; u < NUNIT; u++) begin
                cnt_q[u] <= cnt_d[u];
            end
        end
    end

    // Output drive.
    always_comb begin
        issue_valid = valid_c;
        issue_slot  = slot_c;
        pending     = pending_q;
        for (int u = 0; u < NUNIT; u++) begin
            unit_busy[u] = (cnt_q[u] != '0);
        end
    end

endmodule

// File: tb/tb_unit_sched.sv
// tb_unit_sched: directed bench for unit_sched.
// Instance a: NCOMMIT=32, NUNIT=2, LATENCY=1.
// Instance b: NCOMMIT=32, NUNIT=1, LATENCY=3.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_unit_sched;

    logic        clk;
    logic        reset;

    logic [31:0] a_alloc, a_ready, a_kill, a_pend;
    logic [4:0]  a_head;
    logic [1:0]  a_stall, a_valid, a_busy;
    logic [9:0]  a_slot;

    logic [31:0] b_alloc, b_ready, b_kill, b_pend;
    logic [4:0]  b_head;
    logic [0:0]  b_stall, b_valid, b_busy;
    logic [4:0]  b_slot;

    int checks;
    int errors;

    unit_sched #(.NCOMMIT(32), .NUNIT(2), .LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .alloc(a_alloc), .ready(a_ready), .kill(a_kill),
        .commit_head(a_head), .unit_stall(a_stall), .issue_valid(a_valid),
        .issue_slot(a_slot), .pending(a_pend), .unit_busy(a_busy)
    );

    unit_sched #(.NCOMMIT(32), .NUNIT(1), .LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .alloc(b_alloc), .ready(b_ready), .kill(b_kill),
        .commit_head(b_head), .unit_stall(b_stall), .issue_valid(b_valid),
        .issue_slot(b_slot), .pending(b_pend), .unit_busy(b_busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: returns just after the next falling edge.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        a_alloc = '0; a_ready = '0; a_kill = '0; a_head = '0; a_stall = '0;
        b_alloc = '0; b_ready = '0; b_kill = '0; b_head = '0; b_stall = '0;
        next_cyc();
        next_cyc();
        reset = 1'b0;
        #1;
        check("rst_pend", a_pend, 32'h0);
        check("rst_valid", a_valid, 2'b00);
        check("rst_slot", a_slot, 10'h0);
        check("rst_busy", a_busy, 2'b00);
        check("rst_b_busy", b_busy, 1'b0);

        // Basic issue: four slots, two per cycle, never in allocation cycle.
        a_alloc = 32'h0000_000F; a_ready = '1;
        #1 check("t1_alloc_cyc_valid", a_valid, 2'b00);
        next_cyc();
        a_alloc = '0;
        #1;
        check("t1_pend", a_pend, 32'hF);
        check("t1_c1_valid", a_valid, 2'b11);
        check("t1_c1_slot", a_slot, {5'd1, 5'd0});
        next_cyc(); #1;
        check("t1_c2_valid", a_valid, 2'b11);
        check("t1_c2_slot", a_slot, {5'd3, 5'd2});
        check("t1_c2_pend", a_pend, 32'hC);
        next_cyc(); #1;
        check("t1_c3_valid", a_valid, 2'b00);
        check("t1_c3_pend", a_pend, 32'h0);

        // Wrap around NCOMMIT-1 -> 0 with head = 30.
        a_ready = '0; a_alloc = 32'hC000_0002;
        next_cyc();
        a_alloc = '0; a_ready = '1; a_head = 5'd30;
        #1;
        check("t2_valid", a_valid, 2'b11);
        check("t2_slot", a_slot, {5'd31, 5'd30});
        next_cyc(); #1;
        check("t2_n_valid", a_valid, 2'b01);
        check("t2_n_slot", a_slot, {5'd0, 5'd1});
        next_cyc(); #1;
        check("t2_pend", a_pend, 32'h0);
        a_head = '0;

        // Stall on unit 0.
        a_ready = '0; a_alloc = 32'h0000_0060;
        next_cyc();
        a_alloc = '0; a_ready = '1; a_stall = 2'b01;
        #1;
        check("t3_valid", a_valid, 2'b10);
        check("t3_slot", a_slot, {5'd5, 5'd0});
        next_cyc();
        a_stall = 2'b00;
        #1;
        check("t3_n_valid", a_valid, 2'b01);
        check("t3_n_slot", a_slot, {5'd0, 5'd6});
        check("t3_n_pend", a_pend, 32'h40);
        next_cyc(); #1;
        check("t3_pend", a_pend, 32'h0);

        // Kill an eligible slot; alloc and kill on the same slot.
        a_ready = '0; a_alloc = 32'h0000_0018;
        next_cyc();
        a_alloc = '0; a_ready = '1; a_kill = 32'h8;
        #1;
        check("t4_valid", a_valid, 2'b01);
        check("t4_slot", a_slot, {5'd0, 5'd4});
        next_cyc();
        a_kill = '0;
        #1;
        check("t4_pend", a_pend, 32'h0);
        check("t4_idle", a_valid, 2'b00);
        a_ready = '0; a_alloc = 32'h200; a_kill = 32'h200;
        next_cyc();
        a_alloc = '0; a_kill = '0;
        #1 check("t4_allockill", a_pend, 32'h0);

        // ready low defers; alloc while issuing the same slot keeps it pending.
        a_alloc = 32'h400;
        next_cyc();
        a_alloc = '0;
        #1;
        check("t4_defer_pend", a_pend, 32'h400);
        check("t4_defer_valid", a_valid, 2'b00);
        next_cyc(); #1;
        check("t4_defer_pend2", a_pend, 32'h400);
        a_ready = '1; a_alloc = 32'h400;
        #1;
        check("t4_reuse_valid", a_valid, 2'b01);
        check("t4_reuse_slot", a_slot, {5'd0, 5'd10});
        next_cyc();
        a_alloc = '0; a_ready = '0;
        #1 check("t4_reuse_pend", a_pend, 32'h400);
        a_kill = 32'h400;
        next_cyc();
        a_kill = '0;
        #1 check("t4_kill_pend", a_pend, 32'h0);

        // LATENCY=3, single unit: issues every third cycle.
        b_alloc = 32'h7;
        next_cyc();
        b_alloc = '0; b_ready = '1;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("t5_issue_valid", b_valid, 1'b1);
            check("t5_issue_slot", b_slot, 5'(n));
            check("t5_issue_busy", b_busy, 1'b0);
            for (int w = 0; w < 2; w++) begin
                next_cyc(); #1;
                check("t5_wait_valid", b_valid, 1'b0);
                check("t5_wait_busy", b_busy, 1'b1);
            end
            next_cyc();
        end
        #1;
        check("t5_end_busy", b_busy, 1'b0);
        check("t5_end_pend", b_pend, 32'h0);
        check("t5_end_valid", b_valid, 1'b0);

        // Reset mid-operation with a full pending mask and a busy unit.
        b_ready = '0; b_alloc = 32'hFF;
        next_cyc();
        b_ready = '1; b_alloc = 32'h1;
        #1 check("t6_issue_valid", b_valid, 1'b1);
        next_cyc();
        b_alloc = '0;
        #1;
        check("t6_pre_pend", b_pend, 32'hFF);
        check("t6_pre_busy", b_busy, 1'b1);
        reset = 1'b1;
        a_ready = '1; a_alloc = '0;
        #1;
        check("t6_rst_b_valid", b_valid, 1'b0);
        check("t6_rst_a_valid", a_valid, 2'b00);
        next_cyc();
        reset = 1'b0; b_ready = '0; a_ready = '0;
        #1;
        check("t6_post_pend", b_pend, 32'h0);
        check("t6_post_busy", b_busy, 1'b0);
        check("t6_post_valid", b_valid, 1'b0);
        b_alloc = 32'h20;
        next_cyc();
        b_alloc = '0; b_ready = '1;
        #1;
        check("t6_realloc_valid", b_valid, 1'b1);
        check("t6_realloc_slot", b_slot, 5'd5);
        next_cyc(); #1;
        check("t6_realloc_pend", b_pend, 32'h0);
        check("t6_realloc_busy", b_busy, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unit_sched.md
Name: unit_sched

Overview:
- Parametrised per-unit-class issue scheduler, successor to the fixed-configuration ALU scheduler.
- Tracks which commit slots hold instructions waiting for one class of functional unit (ALU, shift, mul, ...).
- Each cycle, picks the oldest ready slots relative to the commit head and hands them to up to NUNIT units.
- Supports any NUNIT and power-of-2 NCOMMIT, multi-cycle non-pipelined units (busy counters) and squash.

Parameters:
NCOMMIT, 32, number of commit slots (power of 2, 4..64)
LNCOMMIT, $clog2(NCOMMIT), slot index width
NUNIT, 2, number of units in this class (1..4)
LATENCY, 1, unit occupancy in cycles per issue (1 = fully pipelined, max 15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
alloc  in  NCOMMIT  slots allocated to this unit class this cycle
ready  in  NCOMMIT  per-slot operands-ready
kill  in  NCOMMIT  per-slot squash (branch mispredict / trap)
commit_head  in  LNCOMMIT  index of the oldest uncommitted slot
unit_stall  in  NUNIT  unit u cannot accept an instruction this cycle
issue_valid  out  NUNIT  unit u is issued a slot this cycle
issue_slot  out  NUNIT*LNCOMMIT  slot for unit u, field u = bits [u*LNCOMMIT +: LNCOMMIT]
pending  out  NCOMMIT  registered waiting-slot mask
unit_busy  out  NUNIT  unit u is occupied by an earlier multi-cycle issue

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset: pending=0, all busy counters=0, unit_busy=0, issue_valid=0, issue_slot=0.
- eligible = pending & ready & ~kill. alloc only takes effect from the next cycle; a slot is never issued in its allocation cycle.
- Age order:
  - rot[i] = eligible[(commit_head+i) mod NCOMMIT], so rot bit 0 is the oldest slot.
  - Wrap is a plain LNCOMMIT-bit add with carry discarded.
- Free units: free[u] = ~unit_stall[u] & ~unit_busy[u].
- Issue is combinational from registered state plus the inputs, with zero-cycle latency:
  - Free units, taken in ascending u, receive the 1st, 2nd, ... lowest set bits of rot.
  - issue_slot[u] = (commit_head + k) mod NCOMMIT, where k is the chosen rot position.
  - A non-free unit gets issue_valid=0 and issue_slot=0.
  - If there are fewer eligible slots than free units, the highest-index free units stay idle.
  - A slot is never given to two units.
- Pending update (next = ...), in priority order:
  - kill[i] clears bit i (highest priority).
  - alloc[i] sets bit i.
  - Issue of slot i clears bit i.
  - Consequences: alloc and kill on the same slot leave it 0; alloc on a slot being issued the same cycle (slot reuse) leaves it 1.
- Busy counters, LATENCY>1:
  - An issue to unit u loads its counter with LATENCY-1.
  - A non-zero counter decrements each cycle; unit_busy[u] = (counter != 0).
  - kill does not abort a counter: the unit drains.
- LATENCY=1: counters are constant 0 and unit_busy=0.
- ready deasserting on a pending slot only defers it; pending is kept.
- Reset asserted mid-operation clears everything in that cycle; issue_valid is 0 during reset.
- All slots pending and ready: the NUNIT oldest from commit_head are issued, with wrap across NCOMMIT-1 to 0.

Test Plan:
1. Reset, then alloc=0x0000_000F, then ready=all-1, head=0 -> cycle 1: issue_valid=2'b11, slots 0,1. Cycle 2: slots 2,3. Cycle 3: issue_valid=0, pending=0.
2. Wrap: head=30, pending slots {1,30,31}, all ready -> slots 30 and 31 issued. Next cycle slot 1 to unit 0.
3. Stall: unit_stall=2'b01, pending {5,6} ready, head=0 -> only unit 1 issues, slot 5. Next cycle with stall cleared, unit 0 gets slot 6.
4. Kill: pending {3,4} ready, kill=bit 3 -> unit 0 issues slot 4, unit 1 idle, pending=0 next. Alloc+kill on slot 9 same cycle -> pending[9]=0.
5. LATENCY=3, NUNIT=1: pending {0,1,2} ready -> issues at cycles t, t+3, t+6. unit_busy high for 2 cycles after each issue.
6. Reset asserted while pending=0xFF and busy=1 -> next cycle pending=0, unit_busy=0, issue_valid=0. Re-alloc works normally afterwards.
